// File: rtl/mips_pkg.sv
// mips_pkg: shared ALU op codes, datapath width and multiplier sequencer states
package mips_pkg;
  localparam int XLEN = 32;
  localparam logic [2:0] ALUOP_ADD  = 3'b000;
  localparam logic [2:0] ALUOP_SUB  = 3'b001;
  localparam logic [2:0] ALUOP_SLL  = 3'b010;
  localparam logic [2:0] ALUOP_OR   = 3'b011;
  localparam logic [2:0] ALUOP_AND  = 3'b100;
  localparam logic [2:0] ALUOP_SLTU = 3'b101;
  localparam logic [2:0] ALUOP_SLT  = 3'b110;
  localparam logic [2:0] ALUOP_XOR  = 3'b111;
  typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_FIX, ST_DONE} mul_state_t;
endpackage

// File: rtl/mul_sign_fix.sv
// mul_sign_fix: conditional two's-complement negate, used for operand magnitude and product sign fix
module mul_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);
  assign y = neg ? ~a + W'(1) : a;
endmodule

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: 32-step shift-add multiplier borrowing the EX ALU; MUL_SIGNED_EN adds signed MULT with a FIX cycle
module alu_mul_seq
  #(
  parameter int XLEN  = mips_pkg::XLEN,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            sgn,
  input  logic [XLEN-1:0] mcand,
  input  logic [XLEN-1:0] mplier,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic [2:0]      alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_y
);
  import mips_pkg::*;
  mul_state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] m, p_hi, p_lo, sum, a_in, b_in;
  logic [2*XLEN-1:0] prod_fix;
  logic carry, accept, last, fix_en;
  assign ready  = state == ST_IDLE || state == ST_DONE;
  assign busy   = state == ST_ITER || state == ST_FIX;
  assign done   = state == ST_DONE;
  assign accept = start & ready;
  assign last   = cnt == CNT_W'(XLEN - 1);
  assign alu_op = ALUOP_ADD;
  assign alu_a  = p_hi;
  assign alu_b  = m;
  // the ALU has no carry-out, so an unsigned wrap of the sum recovers it
  assign sum    = p_lo[0] ? alu_y : p_hi;
  assign carry  = p_lo[0] & (alu_y < p_hi);
`ifdef MUL_SIGNED_EN
  logic neg, neg_a, neg_b;
  assign neg_a  = sgn & mcand[XLEN-1];
  assign neg_b  = sgn & mplier[XLEN-1];
  assign fix_en = 1'b1;
  mul_sign_fix #(.W(XLEN)) u_mag_a (.a(mcand), .neg(neg_a), .y(a_in));
  mul_sign_fix #(.W(XLEN)) u_mag_b (.a(mplier), .neg(neg_b), .y(b_in));
  mul_sign_fix #(.W(2*XLEN)) u_prod (.a({p_hi, p_lo}), .neg(neg), .y(prod_fix));
  // result sign remembered at accept, applied in FIX
  always_ff @(posedge clk)
    if (reset) neg <= 1'b0;
    else if (accept) neg <= neg_a ^ neg_b;
`else
  logic unused_sgn;
  assign unused_sgn = sgn;
  assign fix_en     = 1'b0;
  assign a_in       = mcand;
  assign b_in       = mplier;
  assign prod_fix   = {p_hi, p_lo};
`endif
  // sequencer state register
  always_ff @(posedge clk)
    if (reset) state <= ST_IDLE;
    else state <= state_n;
  // next state: accept wins from IDLE/DONE, ITER runs until the last count
  always_comb begin
    state_n = accept ? ST_ITER :
              state == ST_ITER ? (last ? (fix_en ? ST_FIX : ST_DONE) : ST_ITER) :
              state == ST_FIX ? ST_DONE : ST_IDLE;
  end
  // operand latch, shift-add step and result capture
  always_ff @(posedge clk)
    if (reset) begin
      cnt  <= '0;
      m    <= '0;
      p_hi <= '0;
      p_lo <= '0;
      hi   <= '0;
      lo   <= '0;
    end else if (accept) begin
      cnt  <= '0;
      m    <= a_in;
      p_hi <= '0;
      p_lo <= b_in;
    end else if (state == ST_ITER) begin
      {p_hi, p_lo} <= {carry, sum, p_lo[XLEN-1:1]};
      cnt <= cnt + CNT_W'(1);
      if (last && !fix_en) {hi, lo} <= {carry, sum, p_lo[XLEN-1:1]};
    end else if (state == ST_FIX) begin
      {hi, lo} <= prod_fix;
    end
endmodule
